axis_pkt_source: RTL

- AXI4-Stream master that generates one packet per `start` pulse.
- Each beat carries an incrementing data pattern (`base_data + beat index`), with `tlast` on the final beat.
- Optional idle gaps between beats; full backpressure handling.
- Drives the slave (s_axis) side of the streaming FIFO path. Used as the on-chip traffic source for FIFO bring-up and loopback tests.

---
 rtl/axis_pkt_source.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/axis_pkt_source.sv
// AXI4-Stream packet generator: one packet per accepted start, beat data = base + index,
// with optional idle gaps between beats and registered, backpressure-safe outputs.
module axis_pkt_source #(
    parameter int unsigned TDATA_WIDTH = 64,
    parameter int unsigned TDATA_BYTES = 8,
    parameter int unsigned LEN_WIDTH   = 16,
    parameter int unsigned GAP_WIDTH   = 8
) (
    input  logic                   m_axis_aclk,
    input  logic                   m_axis_aresetn,
    input  logic                   start,
    input  logic [LEN_WIDTH-1:0]   pkt_len,
    input  logic [TDATA_WIDTH-1:0] base_data,
    input  logic [TDATA_BYTES-1:0] keep_last,
    input  logic [GAP_WIDTH-1:0]   gap_cycles,
    output logic [TDATA_WIDTH-1:0] m_axis_tdata,
    output logic [TDATA_BYTES-1:0] m_axis_tkeep,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   busy,
    output logic                   done,
    output logic [LEN_WIDTH-1:0]   stall_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [TDATA_WIDTH-1:0] base_q, base_d;
    logic [TDATA_BYTES-1:0] keep_q, keep_d;
    logic [GAP_WIDTH-1:0]   gap_q, gap_d;
    logic [GAP_WIDTH-1:0]   gap_cnt_q, gap_cnt_d;
    logic [LEN_WIDTH-1:0]   idx_q, idx_d;
    logic [TDATA_WIDTH-1:0] tdata_q, tdata_d;
    logic [TDATA_BYTES-1:0] tkeep_q, tkeep_d;
    logic                   tlast_q, tlast_d;
    logic                   tvalid_q, tvalid_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [LEN_WIDTH-1:0]   stall_q, stall_d;

    logic [TDATA_BYTES-1:0] keep_eff;
    logic [LEN_WIDTH-1:0]   idx_n;
    logic                   last_n;

    // Next-state and next-output logic; every output is loaded into a register.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        base_d    = base_q;
        keep_d    = keep_q;
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;
        idx_d     = idx_q;
        tdata_d   = tdata_q;
        tkeep_d   = tkeep_q;
        tlast_d   = tlast_q;
        tvalid_d  = tvalid_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        stall_d   = stall_q;
        keep_eff  = (keep_last == '0) ? '1 : keep_last;
        idx_n     = idx_q + LEN_WIDTH'(1);
        last_n    = (idx_n == (len_q - LEN_WIDTH'(1)));

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    stall_d = '0;
                    if (pkt_len != '0) begin
                        len_d    = pkt_len;
                        base_d   = base_data;
                        keep_d   = keep_eff;
                        gap_d    = gap_cycles;
                        idx_d    = '0;
                        busy_d   = 1'b1;
                        tvalid_d = 1'b1;
                        tdata_d  = base_data;
                        tlast_d  = (pkt_len == LEN_WIDTH'(1));
                        tkeep_d  = (pkt_len == LEN_WIDTH'(1)) ? keep_eff : '1;
                        state_d  = ST_SEND;
                    end else begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_SEND: begin
                if (m_axis_tready) begin
                    if (tlast_q) begin
                        tvalid_d = 1'b0;
                        state_d  = ST_FIN;
                    end else begin
                        // Next beat is staged now so it is already stable when tvalid rises.
                        idx_d   = idx_n;
                        tdata_d = base_q + TDATA_WIDTH'(idx_n);
                        tlast_d = last_n;
                        tkeep_d = last_n ? keep_q : '1;
                        if (gap_q != '0) begin
                            tvalid_d  = 1'b0;
                            gap_cnt_d = gap_q - GAP_WIDTH'(1);
                            state_d   = ST_GAP;
                        end
                    end
                end else if (stall_q != '1) begin
                    stall_d = stall_q + LEN_WIDTH'(1);
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    tvalid_d = 1'b1;
                    state_d  = ST_SEND;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
                end
            end
            ST_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            base_q    <= '0;
            keep_q    <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            idx_q     <= '0;
            tdata_q   <= '0;
            tkeep_q   <= '0;
            tlast_q   <= 1'b0;
            tvalid_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            base_q    <= base_d;
            keep_q    <= keep_d;
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
            idx_q     <= idx_d;
            tdata_q   <= tdata_d;
            tkeep_q   <= tkeep_d;
            tlast_q   <= tlast_d;
            tvalid_q  <= tvalid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            stall_q   <= stall_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tkeep  = tkeep_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tvalid = tvalid_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign stall_count   = stall_q;

endmodule
